// File: rtl/i2c_txn_arb.sv
// Two-requester round-robin arbiter and sequencer for the shared I2C master engine.
// Latches the granted requester's fields, launches the engine, supervises it with a
// saturating timeout and returns the result only to the granted requester.
module i2c_txn_arb #(
  parameter int unsigned TOUT_CYC = 50000,
  parameter int unsigned TOUT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rw0,
  input  logic [6:0] dev0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       bsy0,
  output logic       ok0,
  output logic       err0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       rw1,
  input  logic [6:0] dev1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       bsy1,
  output logic       ok1,
  output logic       err1,
  output logic [7:0] rdata1,
  output logic       m_req,
  output logic       m_rw,
  output logic [6:0] m_dev,
  output logic [7:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic [7:0] m_rdata,
  input  logic       m_bsy,
  input  logic       m_ok,
  output logic       gnt
);

  localparam logic [TOUT_W-1:0] ToutLast = TOUT_W'(TOUT_CYC - 1);
  localparam logic [TOUT_W-1:0] CntOne   = TOUT_W'(1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWaitBsy, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [TOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [1:0]        rearm_q, rearm_d;
  logic [1:0]        bsy_q, bsy_d;
  logic [1:0]        ok_q, ok_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              m_rw_q, m_rw_d;
  logic [6:0]        m_dev_q, m_dev_d;
  logic [7:0]        m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [1:0]        elig;
  logic              sel;
  logic              tout;

  assign elig    = {req1, req0} & rearm_q;
  assign tout    = (cnt_q == ToutLast);
  // Saturate rather than wrap so a huge TOUT_CYC can never alias to an early expiry.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

  // Next-state, arbitration and result logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    // A requester becomes eligible again only after its request is seen low.
    rearm_d   = rearm_q | ~{req1, req0};
    bsy_d     = bsy_q;
    ok_d      = '0;
    err_d     = '0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    m_rw_d    = m_rw_q;
    m_dev_d   = m_dev_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    sel       = (&elig) ? ~last_q : elig[1];
    unique case (state_q)
      StIdle: begin
        if (elig != 2'b00) begin
          m_rw_d        = sel ? rw1 : rw0;
          m_dev_d       = sel ? dev1 : dev0;
          m_addr_d      = sel ? addr1 : addr0;
          m_wdata_d     = sel ? wdata1 : wdata0;
          gnt_d         = sel;
          bsy_d[sel]    = 1'b1;
          rearm_d[sel]  = 1'b0;
          state_d       = StLaunch;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWaitBsy;
      end
      StWaitBsy: begin
        if (m_bsy) begin
          cnt_d   = '0;
          state_d = StRun;
        end else if (tout) begin
          err_d[gnt_q] = 1'b1;
          state_d      = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRun: begin
        // Engine completion takes priority over a timeout landing on the same cycle.
        if (!m_bsy) begin
          state_d = StDone;
          if (m_ok) begin
            ok_d[gnt_q] = 1'b1;
            if (m_rw_q) begin
              if (gnt_q) rdata1_d = m_rdata;
              else       rdata0_d = m_rdata;
            end
          end else begin
            err_d[gnt_q] = 1'b1;
          end
        end else if (tout) begin
          err_d[gnt_q] = 1'b1;
          state_d      = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        bsy_d   = '0;
        last_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset returns to idle with requester 0 favoured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      gnt_q     <= 1'b1;
      last_q    <= 1'b1;
      rearm_q   <= 2'b11;
      bsy_q     <= '0;
      ok_q      <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      m_rw_q    <= 1'b0;
      m_dev_q   <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      rearm_q   <= rearm_d;
      bsy_q     <= bsy_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      m_rw_q    <= m_rw_d;
      m_dev_q   <= m_dev_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_req   = (state_q == StLaunch);
  assign m_rw    = m_rw_q;
  assign m_dev   = m_dev_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign gnt     = gnt_q;
  assign bsy0    = bsy_q[0];
  assign bsy1    = bsy_q[1];
  assign ok0     = ok_q[0];
  assign ok1     = ok_q[1];
  assign err0    = err_q[0];
  assign err1    = err_q[1];
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_i2c_txn_arb.sv
// Self-checking bench for i2c_txn_arb: directed scenarios plus randomized transactions,
// predicted by a transaction-level model (grant choice, result cycle, rdata history).
module tb_i2c_txn_arb;

  localparam int TOUT  = 24;
  localparam int NEVER = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] f_req, f_rw;
  logic [6:0] f_dev   [2];
  logic [7:0] f_addr  [2];
  logic [7:0] f_wdata [2];
  logic       eng_bsy, eng_ok;
  logic [7:0] eng_rdata;

  logic       bsy0, ok0, err0, bsy1, ok1, err1;
  logic [7:0] rdata0, rdata1;
  logic       m_req, m_rw, gnt;
  logic [6:0] m_dev;
  logic [7:0] m_addr, m_wdata;

  logic [1:0] bsy_v, ok_v, err_v;
  logic [7:0] rd_v [2];
  assign bsy_v   = {bsy1, bsy0};
  assign ok_v    = {ok1, ok0};
  assign err_v   = {err1, err0};
  assign rd_v[0] = rdata0;
  assign rd_v[1] = rdata1;

  // Transaction-level model state.
  logic [1:0] mr;
  logic       mlast;
  logic [7:0] mrd [2];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  i2c_txn_arb #(.TOUT_CYC(TOUT), .TOUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(f_req[0]), .rw0(f_rw[0]), .dev0(f_dev[0]), .addr0(f_addr[0]), .wdata0(f_wdata[0]),
    .bsy0(bsy0), .ok0(ok0), .err0(err0), .rdata0(rdata0),
    .req1(f_req[1]), .rw1(f_rw[1]), .dev1(f_dev[1]), .addr1(f_addr[1]), .wdata1(f_wdata[1]),
    .bsy1(bsy1), .ok1(ok1), .err1(err1), .rdata1(rdata1),
    .m_req(m_req), .m_rw(m_rw), .m_dev(m_dev), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(eng_rdata), .m_bsy(eng_bsy), .m_ok(eng_ok), .gnt(gnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v);
    f_req[n] = v;
    if (!v) mr[n] = 1'b1;
  endtask

  task automatic model_reset();
    mr     = 2'b11;
    mlast  = 1'b1;
    mrd[0] = 8'h00;
    mrd[1] = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, gnt, 1);
    chk({tag, "_bsy_ok_err"}, {bsy_v, ok_v, err_v}, 0);
    chk({tag, "_mreq_mrw"}, {m_req, m_rw}, 0);
    chk({tag, "_mfields"}, {m_dev, m_addr, m_wdata}, 0);
    chk({tag, "_rdata"}, {rdata1, rdata0}, 0);
  endtask

  // Engine raises m_bsy D cycles after the m_req cycle and holds it L cycles.
  task automatic run_txn(input int d, input int l, input logic okb, input logic [7:0] rd,
                         input logic drop);
    logic el0, el1, seen, quiet, extra, stable, okx;
    int e, off, nb, nok, nerr, pk;
    el0 = f_req[0] & mr[0];
    el1 = f_req[1] & mr[1];
    if (!el0 && !el1) begin
      extra = 1'b0;
      repeat (6) begin
        step();
        if (m_req) extra = 1'b1;
      end
      chk("no_launch_when_ineligible", extra, 0);
      return;
    end
    e = (el0 && el1) ? int'(!mlast) : (el1 ? 1 : 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (m_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mreq_seen", seen, 1);
    if (!seen) return;
    chk("gnt", gnt, e);
    chk("m_rw", m_rw, f_rw[e]);
    chk("m_dev_addr_wdata", {m_dev, m_addr, m_wdata}, {f_dev[e], f_addr[e], f_wdata[e]});
    chk("bsy_at_launch", bsy_v[e], 1);
    mr[e] = 1'b0;
    if (d <= TOUT - 1) begin
      off = d + 2 + ((l < TOUT) ? l : TOUT);
      okx = (l <= TOUT) && okb;
    end else begin
      off = TOUT + 1;
      okx = 1'b0;
    end
    eng_ok = okb;
    eng_rdata = rd;
    nb = 1; nok = 0; nerr = 0; pk = -1;
    quiet = 1'b1; extra = 1'b0; stable = 1'b1;
    for (int k = 1; k <= off + 1; k++) begin
      step();
      eng_bsy = (k >= d + 1) && (k <= d + l);
      if (drop && k == 1) set_req(e, 1'b0);
      if (bsy_v[e]) nb++;
      if (ok_v[e]) begin nok++; pk = k; end
      if (err_v[e]) begin nerr++; pk = k; end
      if (bsy_v[1-e] || ok_v[1-e] || err_v[1-e]) quiet = 1'b0;
      if (m_req) extra = 1'b1;
      if ({m_rw, m_dev, m_addr, m_wdata} !== {f_rw[e], f_dev[e], f_addr[e], f_wdata[e]})
        stable = 1'b0;
    end
    eng_bsy = 1'b0;
    chk("bsy_len", nb, off + 1);
    chk("result_cycle", pk, off);
    chk("ok_count", nok, okx);
    chk("err_count", nerr, !okx);
    chk("other_quiet", quiet, 1);
    chk("single_mreq", extra, 0);
    chk("m_fields_stable", stable, 1);
    mlast = e[0];
    if (okx && f_rw[e]) mrd[e] = rd;
    chk("rdata0", rdata0, mrd[0]);
    chk("rdata1", rdata1, mrd[1]);
  endtask

  task automatic do_reset();
    f_req = 2'b00;
    eng_bsy = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any;
    f_req = 2'b00; f_rw = 2'b00;
    for (int n = 0; n < 2; n++) begin
      f_dev[n] = '0; f_addr[n] = '0; f_wdata[n] = '0;
    end
    eng_bsy = 1'b0; eng_ok = 1'b0; eng_rdata = 8'h00;
    model_reset();
    rst = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    // Single write by requester 0.
    f_rw[0] = 1'b0; f_dev[0] = 7'h50; f_addr[0] = 8'h10; f_wdata[0] = 8'hA5;
    f_dev[1] = 7'h21; f_addr[1] = 8'h44; f_wdata[1] = 8'h5A; f_rw[1] = 1'b0;
    set_req(0, 1'b1);
    run_txn(0, 20, 1'b1, 8'h00, 1'b0);
    set_req(0, 1'b0);
    step();

    // Simultaneous requests after reset: 0 first, then 1 without reassert, twice.
    do_reset();
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    run_txn(0, 5, 1'b1, 8'h00, 1'b0);
    run_txn(1, 3, 1'b1, 8'h00, 1'b0);
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    step();
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    run_txn(0, 2, 1'b1, 8'h00, 1'b0);
    run_txn(0, 2, 1'b1, 8'h00, 1'b0);
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    step();

    // Requester 1: read, write, NACKed read.
    f_rw[1] = 1'b1;
    set_req(1, 1'b1);
    run_txn(0, 6, 1'b1, 8'h3C, 1'b1);
    f_rw[1] = 1'b0;
    set_req(1, 1'b1);
    run_txn(0, 4, 1'b1, 8'h77, 1'b1);
    f_rw[1] = 1'b1;
    set_req(1, 1'b1);
    run_txn(2, 3, 1'b0, 8'h99, 1'b1);

    // Engine never answers; held request must not relaunch until rearmed.
    set_req(0, 1'b1);
    run_txn(NEVER, 1, 1'b1, 8'h00, 1'b0);
    run_txn(0, 3, 1'b1, 8'h00, 1'b0);
    set_req(0, 1'b0);
    step();
    set_req(0, 1'b1);
    run_txn(0, 3, 1'b1, 8'h00, 1'b1);

    // Timeout boundaries: last-chance busy rise, longest legal run, run overrun.
    f_rw[0] = 1'b1;
    set_req(0, 1'b1);
    run_txn(TOUT - 1, 2, 1'b1, 8'hC1, 1'b1);
    set_req(0, 1'b1);
    run_txn(0, TOUT, 1'b1, 8'hC2, 1'b1);
    set_req(0, 1'b1);
    run_txn(0, TOUT + 1, 1'b1, 8'hC3, 1'b1);

    // Randomized transactions.
    for (int it = 0; it < 30; it++) begin
      int d, l;
      for (int n = 0; n < 2; n++) begin
        logic want;
        f_rw[n]    = 1'($urandom_range(0, 1));
        f_dev[n]   = 7'($urandom);
        f_addr[n]  = 8'($urandom);
        f_wdata[n] = 8'($urandom);
        want = 1'($urandom_range(0, 1));
        if (want != f_req[n]) set_req(n, want);
      end
      d = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TOUT + 1));
      l = int'($urandom_range(1, TOUT + 2));
      run_txn(d, l, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while the engine is running.
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    repeat (TOUT + 4) step();
    set_req(0, 1'b1);
    any = 1'b0;
    for (int i = 0; i < 4 && !any; i++) begin
      step();
      any = m_req;
    end
    chk("rst_test_launch", any, 1);
    eng_bsy = 1'b1;
    repeat (3) step();
    chk("rst_test_busy", bsy0, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    eng_bsy = 1'b0;
    f_req = 2'b00;
    step();
    rst = 1'b1;
    model_reset();
    any = 1'b0;
    repeat (8) begin
      step();
      if (m_req) any = 1'b1;
    end
    chk("no_mreq_after_reset", any, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_txn_arb.md
Name: i2c_txn_arb

Overview:
- Two-requester arbiter and sequencer for the single I2C master transaction engine.
- Requester 0 is the UART debug command path; requester 1 is the boot/user configuration path, driven from switches and push buttons.
- Per grant: latches one requester's transaction fields, launches the engine, supervises it with a timeout, and returns the result only to the granted requester.

Parameters:
TOUT_CYC, 16'd50000, max cycles allowed in WAIT_BSY and in RUN before abort (timeout)
TOUT_W, 16, width of the timeout counter

Ports:
clk  in  1  common clock
rst  in  1  asynchronous, active-low reset (clear when rst=0)
req0  in  1  requester 0 transaction request (level)
rw0  in  1  requester 0 direction, 1=read 0=write
dev0  in  7  requester 0 I2C device address
addr0  in  8  requester 0 register address
wdata0  in  8  requester 0 write data
bsy0  out  1  requester 0 transaction in progress
ok0  out  1  requester 0 success pulse
err0  out  1  requester 0 NACK/timeout pulse
rdata0  out  8  requester 0 read data
req1, rw1, dev1, addr1, wdata1, bsy1, ok1, err1, rdata1: same as requester 0, for requester 1
m_req  out  1  engine start pulse
m_rw  out  1  latched direction
m_dev  out  7  latched device address
m_addr  out  8  latched register address
m_wdata  out  8  latched write data
m_rdata  in  8  engine read data, valid when m_bsy falls
m_bsy  in  1  engine busy
m_ok  in  1  engine ACK status, sampled on m_bsy falling edge
gnt  out  1  index of current/last grant

Behaviour:
- Reset values: all outputs 0, except gnt=1.
  - State IDLE; last-grant pointer = 1, so requester 0 wins the first tie.
  - Timeout counter 0; rearm flags set.
- State IDLE:
  - A requester is eligible when reqN=1 and rearmN=1.
  - One eligible requester: grant it.
  - Both eligible: grant the one not equal to the last-grant pointer (round robin).
  - On grant:
    - Latch rwN/devN/addrN/wdataN into m_* registers.
    - Set gnt=N and bsyN=1, both registered in the same cycle.
    - Clear rearmN.
    - Go to LAUNCH.
- State LAUNCH: m_req=1 for exactly one cycle; clear the timeout counter; go to WAIT_BSY.
- State WAIT_BSY:
  - m_bsy=1: clear the counter, go to RUN.
  - Counter reaches TOUT_CYC-1: go to DONE with error.
- State RUN:
  - m_bsy=0: go to DONE.
    - Result = ok if m_ok=1, else err.
    - If m_rw=1 and m_ok=1, capture m_rdata into rdataN.
  - Counter reaches TOUT_CYC-1: go to DONE with error.
- State DONE, one cycle:
  - bsyN=0.
  - Pulse okN or errN (never both).
  - Update the last-grant pointer to N.
  - Go to IDLE.
- Latency:
  - Grant to m_req: 1 cycle (IDLE→LAUNCH).
  - m_bsy fall to okN/errN: 1 cycle.
- Rearm rule: rearmN is set only after reqN is sampled 0 for at least one cycle. A held-high reqN never launches a second transaction.
- The non-granted requester's bsy/ok/err stay 0. Its request stays pending, with no loss, until the next IDLE.
- m_* fields stay stable from LAUNCH through DONE. They are held after DONE until the next grant.
- rdataN keeps its value until the next successful read for that requester. Writes and errors do not change it.
- The timeout counter saturates and does not wrap. Cycles counted include the terminal cycle.
- reqN dropping mid-transaction has no effect; the transaction completes and its result is reported.
- Asynchronous reset mid-transaction:
  - Returns to IDLE immediately with all outputs at reset values.
  - No m_req is issued after reset release unless a fresh request arrives.

Test Plan:
- req0=1 only, rw0=0, dev0=7'h50, addr0=8'h10, wdata0=8'hA5; engine busy 20 cycles with m_ok=1 → m_req pulses once with m_dev=50/m_addr=10/m_wdata=A5; ok0 pulses once; bsy0 high 23 cycles; req1 side stays quiet.
- req0 and req1 raised in the same cycle after reset → requester 0 served first, then requester 1 with no reassert; gnt shows 0 then 1; a second simultaneous pair is served 0 then 1 again (round robin).
- Read by requester 1, m_rdata=8'h3C, m_ok=1 → rdata1=3C with ok1; a following write by requester 1 leaves rdata1=3C.
- NACK: m_ok=0 at m_bsy fall → err1 pulses, ok1 stays 0, rdata1 unchanged.
- Engine never raises m_bsy, TOUT_CYC=8 → err0 exactly 9 cycles after m_req; no engine activity afterward; with req0 held high, no relaunch until req0 goes low for ≥1 cycle and then high.
- rst driven low during RUN → all outputs 0 and gnt=1 the same cycle; after release with no requests, m_req stays 0.
